// File: rtl/biss_pkg.sv
// Shared BiSS definitions: frame FSM states, health codes and default CRC settings.
package biss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_START,
    ST_CDS,
    ST_DATA,
    ST_STAT,
    ST_CRC,
    ST_CHECK
  } state_e;

  localparam logic [1:0] HEALTH_OK      = 2'd0;
  localparam logic [1:0] HEALTH_CRC     = 2'd1;
  localparam logic [1:0] HEALTH_TIMEOUT = 2'd2;
  localparam logic [1:0] HEALTH_NOFRAME = 2'd3;

  localparam int         DEF_CRC_W    = 6;
  localparam logic [5:0] DEF_CRC_POLY = 6'h03;

endpackage

// File: rtl/biss_crc_lfsr.sv
// Serial CRC LFSR, MSB-first, zero init; clear has priority over shift.
module biss_crc_lfsr
  import biss_pkg::*;
#(
  parameter int               CRC_W    = DEF_CRC_W,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEF_CRC_POLY)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = din ^ crc_q[CRC_W-1];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (shift) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/biss_monitor.sv
// Passive BiSS-C listener: decodes position, nE/nW and CRC from a sniffed MA/SLO pair.
// Results register one cycle after CHECK; a frame stalled with MA high is aborted.
module biss_monitor
  import biss_pkg::*;
#(
  parameter int               MAX_BITS       = 64,
  parameter int               POSN_W         = 32,
  parameter int               CRC_W          = DEF_CRC_W,
  parameter logic [CRC_W-1:0] CRC_POLY       = CRC_W'(DEF_CRC_POLY),
  parameter int               TIMEOUT_CYCLES = 125,
  parameter int               SYNC_STAGES    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [7:0]        BITS,
  input  logic              ssi_sck_i,
  input  logic              ssi_dat_i,
  output logic [POSN_W-1:0] posn_o,
  output logic              posn_valid_o,
  output logic              error_o,
  output logic              warning_o,
  output logic              crc_err_o,
  output logic [1:0]        health_o
);

  localparam int         CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         IDX_W      = $clog2(MAX_BITS);
  localparam logic [8:0] MAX_BITS_L = 9'(MAX_BITS);

  logic [SYNC_STAGES-1:0] sck_sync_q, dat_sync_q;
  logic                   sck_prev_q;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  state_e                 state_q, state_d;
  logic [7:0]             bits_q, bits_d, cnt_q, cnt_d;
  logic [MAX_BITS-1:0]    data_q, data_d;
  logic                   ne_q, ne_d, nw_q, nw_d;
  logic [CRC_W-1:0]       rx_crc_q, rx_crc_d;
  logic [POSN_W-1:0]      posn_q, posn_d, posn_ext;
  logic                   valid_q, valid_d, error_q, error_d, warning_q, warning_d;
  logic                   crc_err_q, crc_err_d;
  logic [1:0]             health_q, health_d;

  logic             sck_s, dat_s, sck_edge, timeout, bits_bad, crc_ok, sign_bit;
  logic [IDX_W-1:0] msb_idx;
  logic             lfsr_clear, lfsr_shift;
  logic [CRC_W-1:0] lfsr_crc;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign sck_edge = sck_s & ~sck_prev_q;
  assign timeout  = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign bits_bad = (BITS == 8'd0) || ({1'b0, BITS} > MAX_BITS_L);
  assign crc_ok   = (~rx_crc_q == lfsr_crc);

  biss_crc_lfsr #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (lfsr_clear),
    .shift   (lfsr_shift),
    .din     (dat_s),
    .crc_o   (lfsr_crc)
  );

  // Sign-extend from the latched MSB; for wide frames every index is below bits_q.
  always_comb begin
    msb_idx  = IDX_W'(bits_q - 8'd1);
    sign_bit = data_q[msb_idx];
    posn_ext = '0;
    for (int i = 0; i < POSN_W; i++) begin
      posn_ext[i] = (i < int'(bits_q)) ? data_q[i] : sign_bit;
    end
  end

  always_comb begin
    idle_cnt_d = !sck_s ? '0 : (timeout ? idle_cnt_q : idle_cnt_q + 1'b1);
    state_d    = state_q;
    bits_d     = bits_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    ne_d       = ne_q;
    nw_d       = nw_q;
    rx_crc_d   = rx_crc_q;
    posn_d     = posn_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    warning_d  = warning_q;
    crc_err_d  = 1'b0;
    health_d   = health_q;
    lfsr_clear = 1'b0;
    lfsr_shift = 1'b0;
    if ((state_q != ST_IDLE) && timeout) begin
      state_d  = ST_IDLE;
      health_d = HEALTH_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lfsr_clear = 1'b1;
          cnt_d      = '0;
          if (!sck_s) begin
            bits_d = BITS;
            data_d = '0;
            if (bits_bad) health_d = HEALTH_NOFRAME;
            else          state_d  = ST_ACK;
          end
        end
        ST_ACK:   if (sck_edge && !dat_s) state_d = ST_START;
        ST_START: if (sck_edge && dat_s)  state_d = ST_CDS;
        ST_CDS:   if (sck_edge)           state_d = ST_DATA;
        ST_DATA: if (sck_edge) begin
          data_d     = {data_q[MAX_BITS-2:0], dat_s};
          lfsr_shift = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q == bits_q - 8'd1) begin
            cnt_d   = '0;
            state_d = ST_STAT;
          end
        end
        ST_STAT: if (sck_edge) begin
          lfsr_shift = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q == 8'd0) begin
            ne_d = dat_s;
          end else begin
            nw_d    = dat_s;
            cnt_d   = '0;
            state_d = ST_CRC;
          end
        end
        ST_CRC: if (sck_edge) begin
          rx_crc_d = {rx_crc_q[CRC_W-2:0], dat_s};
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == 8'(CRC_W - 1)) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (crc_ok) begin
            posn_d    = posn_ext;
            valid_d   = 1'b1;
            error_d   = ~ne_q;
            warning_d = ~nw_q;
            health_d  = HEALTH_OK;
          end else begin
            crc_err_d = 1'b1;
            health_d  = HEALTH_CRC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync_q <= '1;
      dat_sync_q <= '1;
      sck_prev_q <= 1'b1;
      idle_cnt_q <= '0;
      state_q    <= ST_IDLE;
      bits_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      ne_q       <= 1'b1;
      nw_q       <= 1'b1;
      rx_crc_q   <= '0;
      posn_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      warning_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      health_q   <= HEALTH_NOFRAME;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], ssi_sck_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ssi_dat_i};
      sck_prev_q <= sck_s;
      idle_cnt_q <= idle_cnt_d;
      state_q    <= state_d;
      bits_q     <= bits_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      ne_q       <= ne_d;
      nw_q       <= nw_d;
      rx_crc_q   <= rx_crc_d;
      posn_q     <= posn_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      warning_q  <= warning_d;
      crc_err_q  <= crc_err_d;
      health_q   <= health_d;
    end
  end

  assign posn_o       = posn_q;
  assign posn_valid_o = valid_q;
  assign error_o      = error_q;
  assign warning_o    = warning_q;
  assign crc_err_o    = crc_err_q;
  assign health_o     = health_q;

endmodule

// File: tb/tb_biss_monitor.sv
// Directed bench for biss_monitor: drives BiSS-C frames on sck/dat and checks decoded results.
module tb_biss_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  bits = 8'd32;
  logic        sck = 1'b1;
  logic        dat = 1'b1;
  logic [31:0] posn;
  logic        posn_valid, error, warning, crc_err;
  logic [1:0]  health;

  int checks = 0;
  int errors = 0;
  int n_vld = 0;
  int n_crc = 0;
  int v0, c0, vld_at, crc_at;

  always #5 clk = ~clk;

  biss_monitor dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .BITS         (bits),
    .ssi_sck_i    (sck),
    .ssi_dat_i    (dat),
    .posn_o       (posn),
    .posn_valid_o (posn_valid),
    .error_o      (error),
    .warning_o    (warning),
    .crc_err_o    (crc_err),
    .health_o     (health)
  );

  always @(posedge clk) begin
    if (posn_valid) n_vld <= n_vld + 1;
    if (crc_err)    n_crc <= n_crc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of msg(x)*x^6 divided by x^6+x+1.
  function automatic logic [5:0] crc_model(input logic [79:0] msg, input int n);
    logic [6:0] r;
    logic       b;
    r = '0;
    for (int i = n - 1; i >= -6; i--) begin
      b = (i >= 0) ? msg[i] : 1'b0;
      r = {r[5:0], b};
      if (r[6]) r = r ^ 7'h43;
    end
    return r[5:0];
  endfunction

  task automatic send_bit(input logic b, input bit last);
    @(negedge clk);
    sck = 1'b0;
    dat = b;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    if (!last) repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] d, input int nb, input logic ne, input logic nw,
                            input logic [5:0] flip);
    logic [79:0] msg;
    logic [5:0]  tx;
    msg = '0;
    for (int i = 0; i < nb; i++) msg[i+2] = d[i];
    msg[1] = ne;
    msg[0] = nw;
    tx = ~crc_model(msg, nb + 2) ^ flip;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    for (int i = nb - 1; i >= 0; i--) send_bit(d[i], 0);
    send_bit(ne, 0);
    send_bit(nw, 0);
    for (int i = 5; i >= 0; i--) send_bit(tx[i], i == 0);
  endtask

  task automatic send_partial(input logic [31:0] d, input int n);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    for (int i = 0; i < n; i++) send_bit(d[31-i], i == n - 1);
  endtask

  // Cycle index (posedges after the last sck rise is driven) of first valid / crc strobe.
  task automatic wait_result(output int va, output int ca);
    va = 0;
    ca = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (posn_valid && va == 0) va = c;
      if (crc_err && ca == 0) ca = c;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_posn"}, posn, 64'h0);
    check({tag, "_vld"}, posn_valid, 64'h0);
    check({tag, "_err"}, error, 64'h0);
    check({tag, "_warn"}, warning, 64'h0);
    check({tag, "_crc"}, crc_err, 64'h0);
    check({tag, "_health"}, health, 64'h3);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_state("idle");

    // Good 32-bit frame, no error/warning.
    v0 = n_vld; c0 = n_crc;
    send_frame(64'h12345678, 32, 1'b1, 1'b1, 6'h00);
    wait_result(vld_at, crc_at);
    check("f1_lat", vld_at, 4);
    check("f1_posn", posn, 64'h12345678);
    check("f1_nvld", n_vld - v0, 1);
    check("f1_ncrc", n_crc - c0, 0);
    check("f1_err", error, 0);
    check("f1_warn", warning, 0);
    check("f1_health", health, 0);

    // 18-bit frame with MSB set: sign-extended, encoder error flagged.
    bits = 8'd18;
    v0 = n_vld;
    send_frame(64'h3FFFF, 18, 1'b0, 1'b1, 6'h00);
    wait_result(vld_at, crc_at);
    check("f2_lat", vld_at, 4);
    check("f2_posn", posn, 64'hFFFFFFFF);
    check("f2_nvld", n_vld - v0, 1);
    check("f2_err", error, 1);
    check("f2_warn", warning, 0);

    // Corrupted CRC: strobe crc_err, hold previous results.
    bits = 8'd32;
    v0 = n_vld; c0 = n_crc;
    send_frame(64'h12345678, 32, 1'b1, 1'b1, 6'h04);
    wait_result(vld_at, crc_at);
    check("f3_crc_lat", crc_at, 4);
    check("f3_ncrc", n_crc - c0, 1);
    check("f3_nvld", n_vld - v0, 0);
    check("f3_health", health, 1);
    check("f3_posn", posn, 64'hFFFFFFFF);
    check("f3_err", error, 1);
    check("f3_warn", warning, 0);

    // Stall with sck high after 10 data bits.
    v0 = n_vld; c0 = n_crc;
    send_partial(32'hA5A5A5A5, 10);
    repeat (100) @(negedge clk);
    check("to_early_health", health, 1);
    repeat (100) @(negedge clk);
    check("to_health", health, 2);
    check("to_nvld", n_vld - v0, 0);
    check("to_ncrc", n_crc - c0, 0);
    send_frame(64'h0BADF00D, 32, 1'b1, 1'b0, 6'h00);
    wait_result(vld_at, crc_at);
    check("to_next_posn", posn, 64'h0BADF00D);
    check("to_next_warn", warning, 1);
    check("to_next_health", health, 0);

    // Illegal BITS values.
    foreach (bits_bad_tbl[k]) begin
      bits = bits_bad_tbl[k];
      v0 = n_vld; c0 = n_crc;
      send_frame(64'h11112222, 32, 1'b1, 1'b1, 6'h00);
      wait_result(vld_at, crc_at);
      check("cfg_health", health, 3);
      check("cfg_strobes", (n_vld - v0) + (n_crc - c0), 0);
    end
    bits = 8'd32;
    v0 = n_vld;
    send_frame(64'h87654321, 32, 1'b1, 1'b1, 6'h00);
    wait_result(vld_at, crc_at);
    check("cfg_ok_posn", posn, 64'h87654321);
    check("cfg_ok_nvld", n_vld - v0, 1);
    check("cfg_ok_health", health, 0);

    // Reset in the middle of DATA.
    send_partial(32'hFFFF0000, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid");
    repeat (5) @(negedge clk);
    v0 = n_vld;
    send_frame(64'hCAFE0001, 32, 1'b1, 1'b0, 6'h00);
    wait_result(vld_at, crc_at);
    check("mid_lat", vld_at, 4);
    check("mid_posn", posn, 64'hCAFE0001);
    check("mid_nvld", n_vld - v0, 1);
    check("mid_warn", warning, 1);
    check("mid_health", health, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [7:0] bits_bad_tbl [2] = '{8'd0, 8'd70};

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/biss_monitor.md
Name: biss_monitor

Overview:
Passive BiSS-C listener on an externally mastered encoder link: MA clock on ssi_sck_i, SLO data on ssi_dat_i.
- Generalises the fixed 32-bit sniffer: runtime position length up to MAX_BITS, parametrised CRC polynomial/width, nE/nW status capture, frame timeout/abort, health reporting.
- Sits in the encoder input path next to the SSI/BiSS masters; feeds position and status to the position bus.

Parameters:
MAX_BITS, 64, maximum position bits per frame; legal BITS range is 1..MAX_BITS.
POSN_W, 32, width of posn_o.
CRC_W, 6, CRC length in bits.
CRC_POLY, 6'h03, CRC polynomial without the implicit top term (x^6+x+1).
TIMEOUT_CYCLES, 125, clk_i cycles with sck held high that end or abort a frame.
SYNC_STAGES, 2, synchroniser depth on both line inputs.

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous active-high reset
BITS  in  8  position bit count, latched at frame start
ssi_sck_i  in  1  MA clock, asynchronous, idles high
ssi_dat_i  in  1  SLO data, asynchronous
posn_o  out  POSN_W  last CRC-good position
posn_valid_o  out  1  one-cycle strobe when posn_o updates
error_o  out  1  inverted nE of last good frame (1 = encoder error)
warning_o  out  1  inverted nW of last good frame (1 = warning)
crc_err_o  out  1  one-cycle strobe on CRC mismatch
health_o  out  2  0 ok, 1 CRC error, 2 timeout/framing, 3 no frame/bad config

Behaviour:
- Reset values: posn_o=0, posn_valid_o=0, error_o=0, warning_o=0, crc_err_o=0, health_o=3, FSM=IDLE.
- Synchronisation: both inputs pass SYNC_STAGES flops.
- All sampling occurs on the clk_i cycle where synced sck shows a 0->1 transition ("edge").
- Idle counter: counts while synced sck=1; clears on sck=0; saturates at TIMEOUT_CYCLES.
- FSM:
  - IDLE: stay while sck high. On first sck low: latch BITS; if BITS=0 or BITS>MAX_BITS, stay IDLE with health_o=3; else go to ACK.
  - ACK: wait for an edge sampling dat=0; go to START.
  - START: wait for an edge sampling dat=1 (start bit); go to CDS.
  - CDS: one edge, bit discarded; go to DATA.
  - DATA: latched-BITS edges, shifted MSB first into a MAX_BITS register; go to STAT.
  - STAT: two edges, nE then nW; go to CRC.
  - CRC: CRC_W edges; go to CHECK.
  - CHECK: one cycle; go to IDLE.
- CRC calculation:
  - Serial LFSR, init 0, fed with data bits then nE, nW.
  - Received CRC is inverted on the line.
  - Pass condition: ~rx_crc == lfsr.
- Pass, registered in the cycle after CHECK:
  - posn_valid_o=1 for one cycle.
  - posn_o = data sign-extended from bit BITS-1 when BITS<POSN_W; low POSN_W bits when BITS>=POSN_W.
  - error_o=~nE, warning_o=~nW, health_o=0.
- Fail: crc_err_o=1 for one cycle; health_o=1; posn_o, error_o and warning_o hold.
- Latency: posn_valid_o rises exactly 2 clk_i cycles after the edge cycle of the last CRC bit.
- Timeout: idle counter reaching TIMEOUT_CYCLES in any state other than IDLE aborts to IDLE; health_o=2; no posn/crc strobes.
- Health_o=3 is reached only from reset or bad config. A bad-config condition clears on the next valid frame.
- BITS changes mid-frame have no effect until the next frame.
- reset_i asserted mid-frame: all state returns to reset values on the next clk_i edge.

Decomposition:
- Shared package biss_pkg:
  - FSM state enum.
  - Health code constants HEALTH_OK/CRC/TIMEOUT/NOFRAME.
  - Default CRC_POLY/CRC_W constants.
- One sub-module, biss_crc_lfsr: parameters CRC_W, CRC_POLY; ports clk_i, reset_i, clear, shift, din, crc_o. Reused by the BiSS master.
- Synchronisers use the existing sync flop primitive.

Test Plan:
- BITS=32, frame posn 0x12345678, nE=1, nW=1, correct inverted CRC from bench model -> posn_o=0x12345678, one posn_valid_o pulse, error_o=0, warning_o=0, health_o=0, posn_valid_o 2 cycles after last CRC edge.
- BITS=18, posn 0x3FFFF, nE=0, nW=1 -> posn_o=0xFFFFFFFF (sign-extended), error_o=1, warning_o=0.
- Same as the first frame but one CRC bit flipped -> crc_err_o one pulse, health_o=1, posn_o holds the previous value, no posn_valid_o.
- Frame stopped with sck high after 10 data bits, held 200 cycles -> abort at 125 cycles, health_o=2, no strobes; the next good frame is decoded and health_o=0.
- BITS=0, then BITS=70 with MAX_BITS=64 -> health_o=3, no strobes. Set BITS=32 and send a good frame -> decoded.
- reset_i pulsed during DATA -> all outputs at reset values; the following complete frame decodes correctly.
